register_writeback: RTL

Write-back side of the SPU 128-entry × 128-bit register file. It accepts results from the even and odd execution pipes and delays each through a fixed-depth write-back pipeline. It then commits them into the register array and exposes a combinational read port for the operand-fetch stage. After every reset, a sequential clear engine zeroes the array one entry per cycle before results are accepted.

---
 rtl/register_writeback.sv | 108 ++++++++++
 1 files changed

// File: rtl/register_writeback.sv
// register_writeback: SPU register-file write-back pipeline, commit and clear engine; define WB_BYPASS_EN to forward pending stage-WB_STAGES data to rd_data
module register_writeback #(
  parameter int WB_STAGES = 2,
  parameter int REG_COUNT = 128,
  parameter int DATA_W = 128,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_even,
  input  logic [AW-1:0]     wr_addr_even,
  input  logic [DATA_W-1:0] wr_data_even,
  input  logic              wr_en_odd,
  input  logic [AW-1:0]     wr_addr_odd,
  input  logic [DATA_W-1:0] wr_data_odd,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              init_busy,
  output logic              wr_collision
);
  typedef enum logic {INIT, RUN} state_t;
  state_t r_state, w_next_state;
  logic w_run;
  logic [AW-1:0] r_clr_cnt;
  logic r_ve [1:WB_STAGES];
  logic r_vo [1:WB_STAGES];
  logic [AW-1:0] r_ae [1:WB_STAGES];
  logic [AW-1:0] r_ao [1:WB_STAGES];
  logic [DATA_W-1:0] r_de [1:WB_STAGES];
  logic [DATA_W-1:0] r_do [1:WB_STAGES];
  logic [DATA_W-1:0] r_mem [REG_COUNT];
  logic r_collision;
  logic w_ce, w_co;
  logic [AW-1:0] w_cae, w_cao;
  logic [DATA_W-1:0] w_cde, w_cdo;
  assign w_ce = r_ve[WB_STAGES];
  assign w_co = r_vo[WB_STAGES];
  assign w_cae = r_ae[WB_STAGES];
  assign w_cao = r_ao[WB_STAGES];
  assign w_cde = r_de[WB_STAGES];
  assign w_cdo = r_do[WB_STAGES];
  assign wr_collision = r_collision;
  // state register: every reset restarts the clear engine
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= INIT;
    else r_state <= w_next_state;
  // next state: leave INIT on the edge that clears the last entry
  always_comb
    w_next_state = (r_state == INIT && r_clr_cnt == AW'(REG_COUNT - 1)) ? RUN : r_state;
  // state-derived outputs
  always_comb begin
    init_busy = (r_state == INIT);
    w_run = (r_state == RUN);
  end
  // clear pointer advances once per INIT cycle and wraps to 0 as RUN begins
  always_ff @(posedge clk or posedge reset)
    if (reset) r_clr_cnt <= '0;
    else if (r_state == INIT) r_clr_cnt <= r_clr_cnt + 1'b1;
  // valid bits shift per pipe; inputs only enter while running
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int s = 1; s <= WB_STAGES; s++) begin
        r_ve[s] <= 1'b0;
        r_vo[s] <= 1'b0;
      end
    end else begin
      r_ve[1] <= wr_en_even & w_run;
      r_vo[1] <= wr_en_odd & w_run;
      for (int s = 2; s <= WB_STAGES; s++) begin
        r_ve[s] <= r_ve[s-1];
        r_vo[s] <= r_vo[s-1];
      end
    end
  // address/data payload shifts alongside the valids without reset
  always_ff @(posedge clk) begin
    r_ae[1] <= wr_addr_even;
    r_ao[1] <= wr_addr_odd;
    r_de[1] <= wr_data_even;
    r_do[1] <= wr_data_odd;
    for (int s = 2; s <= WB_STAGES; s++) begin
      r_ae[s] <= r_ae[s-1];
      r_ao[s] <= r_ao[s-1];
      r_de[s] <= r_de[s-1];
      r_do[s] <= r_do[s-1];
    end
  end
  // array write: clear during INIT, else commit; odd is written last so it wins a shared address
  always_ff @(posedge clk)
    if (r_state == INIT) r_mem[r_clr_cnt] <= '0;
    else begin
      if (w_ce) r_mem[w_cae] <= w_cde;
      if (w_co) r_mem[w_cao] <= w_cdo;
    end
  // one-cycle flag for a dual commit to the same register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_collision <= 1'b0;
    else r_collision <= w_ce & w_co & (w_cae == w_cao);
`ifdef WB_BYPASS_EN
  // read port forwards the entry about to commit, odd before even
  always_comb
    rd_data = (w_co && w_cao == rd_addr) ? w_cdo :
              (w_ce && w_cae == rd_addr) ? w_cde : r_mem[rd_addr];
`else
  // read port returns the array contents only
  always_comb
    rd_data = r_mem[rd_addr];
`endif
endmodule
